// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : E-stage multiply/divide unit. Owns the architectural HI/LO
//            registers, executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle
//            latency and MTHI/MTLO in a single cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MULT_CYCLES : cycles busy stays high for MULT/MULTU (>= 1)
//   DIV_CYCLES  : cycles busy stays high for DIV/DIVU   (>= 1)
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  asynchronous active-high reset
//   start  in   1  issue strobe for md_op
//   md_op  in   3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   A      in  32  rs operand (dividend / multiplicand / MT data)
//   B      in  32  rt operand (divisor / multiplier)
//   cancel in   1  flush of the E-stage op (only with MD_CANCEL_EN)
//   busy   out  1  high while a MULT/DIV is in flight
//   HI     out 32  architectural HI register
//   LO     out 32  architectural LO register
// Configuration macro:
//   MD_CANCEL_EN : adds the cancel input (abort in flight / suppress issue)
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_write;

  logic             cancel_in;

`ifdef MD_CANCEL_EN
  assign cancel_in = cancel;
`else
  assign cancel_in = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Result datapath (operands as sampled at the issue edge)
  // --------------------------------------------------------------------------
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor_nz;
  logic        [31:0] uq, ur;
  logic        [31:0] abs_a, abs_b, abs_b_nz;
  logic        [31:0] sq_mag, sr_mag, sq, sr;
  logic        [31:0] nxt_hi, nxt_lo;
  logic               nxt_write;
  logic               is_long_op;

  always_comb begin
    prod_s = $signed(A) * $signed(B);
    prod_u = {32'd0, A} * {32'd0, B};

    // A zero divisor is replaced by 1 only to keep the dividers well defined;
    // the result is never committed in that case.
    divisor_nz = (B == 32'd0) ? 32'd1 : B;
    uq         = A / divisor_nz;
    ur         = A % divisor_nz;

    // Signed divide through magnitudes: quotient truncates toward zero and
    // the remainder takes the dividend's sign. 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 from the 32-bit wrap of the negate.
    abs_a    = A[31] ? (32'd0 - A) : A;
    abs_b    = B[31] ? (32'd0 - B) : B;
    abs_b_nz = (abs_b == 32'd0) ? 32'd1 : abs_b;
    sq_mag   = abs_a / abs_b_nz;
    sr_mag   = abs_a % abs_b_nz;
    sq       = (A[31] ^ B[31]) ? (32'd0 - sq_mag) : sq_mag;
    sr       = A[31] ? (32'd0 - sr_mag) : sr_mag;

    nxt_hi     = 32'd0;
    nxt_lo     = 32'd0;
    nxt_write  = 1'b0;
    is_long_op = 1'b0;
    case (md_op)
      OP_MULT: begin
        nxt_hi     = prod_s[63:32];
        nxt_lo     = prod_s[31:0];
        nxt_write  = 1'b1;
        is_long_op = 1'b1;
      end
      OP_MULTU: begin
        nxt_hi     = prod_u[63:32];
        nxt_lo     = prod_u[31:0];
        nxt_write  = 1'b1;
        is_long_op = 1'b1;
      end
      OP_DIV: begin
        nxt_hi     = sr;
        nxt_lo     = sq;
        nxt_write  = (B != 32'd0);
        is_long_op = 1'b1;
      end
      OP_DIVU: begin
        nxt_hi     = ur;
        nxt_lo     = uq;
        nxt_write  = (B != 32'd0);
        is_long_op = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered busy and HI/LO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      counter    <= '0;
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_write <= 1'b0;
      HI         <= 32'd0;
      LO         <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel_in) begin
            if (is_long_op) begin
              pend_hi    <= nxt_hi;
              pend_lo    <= nxt_lo;
              pend_write <= nxt_write;
              counter    <= md_op[1] ? DIV_LOAD : MULT_LOAD;
              busy       <= 1'b1;
              state      <= RUN;
            end else if (md_op == OP_MTHI) begin
              HI <= A;
            end else if (md_op == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        RUN: begin
          // Any start seen here is ignored: the hazard unit should have stalled it.
          if (cancel_in) begin
            pend_write <= 1'b0;
            counter    <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            if (pend_write) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
            pend_write <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Self-checking bench for md_unit: directed vector table for each
//            op class plus hand sequences for ignored issue, async reset
//            mid-op and (with MD_CANCEL_EN) cancel behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;
`ifdef MD_CANCEL_EN
  logic        cancel;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
`ifdef MD_CANCEL_EN
    .cancel(cancel),
`endif
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and run until busy drops; returns number of busy samples
  // and whether HI/LO held their previous values throughout.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic held);
    logic [31:0] ph, pl;
    ph = HI;
    pl = LO;
    held = 1'b1;
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin
      if (HI !== ph || LO !== pl) held = 1'b0;
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc;
    logic        held;
    string       nm;

    //            op     A             B             HI            LO            cycles
    vecs[0]  = '{3'd4, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
    vecs[1]  = '{3'd5, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
    vecs[2]  = '{3'd0, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[3]  = '{3'd1, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[4]  = '{3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[5]  = '{3'd3, 32'h7,        32'h2,        32'h00000001, 32'h00000003, 10};
    vecs[6]  = '{3'd4, 32'hAAAA0000, 32'h0,        32'hAAAA0000, 32'h00000003, 0};
    vecs[7]  = '{3'd5, 32'h0000BBBB, 32'h0,        32'hAAAA0000, 32'h0000BBBB, 0};
    vecs[8]  = '{3'd2, 32'h5,        32'h0,        32'hAAAA0000, 32'h0000BBBB, 10};
    vecs[9]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[10] = '{3'd0, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 5};
    vecs[11] = '{3'd2, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[12] = '{3'd3, 32'h5,        32'h0,        32'h00000001, 32'hFFFFFFFD, 10};
    vecs[13] = '{3'd6, 32'hDEADBEEF, 32'h1,        32'h00000001, 32'hFFFFFFFD, 0};
    vecs[14] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[15] = '{3'd2, 32'hFFFFFFF8, 32'h3,        32'hFFFFFFFE, 32'hFFFFFFFE, 10};

    reset = 1'b1; start = 1'b0; md_op = 3'd7; A = '0; B = '0;
`ifdef MD_CANCEL_EN
    cancel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, cyc, held);
      nm = $sformatf("v%0d", i);
      chk({nm, "_busy_cycles"}, 32'(cyc), 32'(vecs[i].cyc));
      chk({nm, "_hold"}, {31'd0, held}, 32'd1);
      chk({nm, "_hi"}, HI, vecs[i].hi);
      chk({nm, "_lo"}, LO, vecs[i].lo);
    end

    // MULT in flight with an MTLO strobe on its third busy cycle: ignored.
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin
      if (cyc == 2) begin
        start = 1'b1; md_op = 3'd5; A = 32'h1;
      end
      cyc++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("ign_busy_cycles", 32'(cyc), 32'd5);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd12);
    repeat (2) @(posedge clk); #1;
    chk("ign_lo_late", LO, 32'd12);

    // Async reset in the middle of a MULT: immediate clear, op discarded.
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; A = 32'd5; B = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_hi", HI, 32'd0);
    chk("rst_async_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("rst_discard_busy", {31'd0, busy}, 32'd0);
    chk("rst_discard_lo", LO, 32'd0);

`ifdef MD_CANCEL_EN
    issue(3'd4, 32'h11, 32'h0, cyc, held);
    issue(3'd5, 32'h22, 32'h0, cyc, held);
    // DIV cancelled during its fourth busy cycle.
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("cxl_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cxl_busy_after", {31'd0, busy}, 32'd0);
    repeat (12) @(posedge clk); #1;
    chk("cxl_busy_later", {31'd0, busy}, 32'd0);
    chk("cxl_hi", HI, 32'h11);
    chk("cxl_lo", LO, 32'h22);
    // MTHI issued together with cancel: suppressed.
    @(negedge clk);
    start = 1'b1; md_op = 3'd4; A = 32'hFFFF0000; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("cxl_mthi_hi", HI, 32'h11);
    chk("cxl_mthi_busy", {31'd0, busy}, 32'd0);
    // MULT issued together with cancel: never goes busy.
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; A = 32'd2; B = 32'd2; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("cxl_mult_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(posedge clk); #1;
    chk("cxl_mult_lo", LO, 32'h22);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
